// File: rtl/bypass_network_pkg.sv
// Shared types for the operand-bypass network: window entry layout and the
// bundled port views used by the integer pipeline.
package bypass_network_pkg;

    localparam int BYP_XLEN  = 32;
    localparam int BYP_NREAD = 2;
    localparam int REG_AW    = 5;

    typedef struct packed {
        logic                valid;
        logic [REG_AW-1:0]   waddr;
        logic [BYP_XLEN-1:0] wdata;
        logic                ready;
    } bypass_entry_type;

    typedef struct packed {
        logic                                 hold;
        logic                                 issue_wren;
        logic [REG_AW-1:0]                    issue_waddr;
        logic [BYP_XLEN-1:0]                  issue_wdata;
        logic                                 issue_ready;
        logic                                 late_valid;
        logic [BYP_XLEN-1:0]                  late_wdata;
        logic [BYP_NREAD-1:0]                 rden;
        logic [BYP_NREAD-1:0][REG_AW-1:0]     raddr;
        logic [BYP_NREAD-1:0][BYP_XLEN-1:0]   rdata;
    } bypass_in_type;

    typedef struct packed {
        logic [BYP_NREAD-1:0][BYP_XLEN-1:0]   data;
        logic [BYP_NREAD-1:0]                 hazard;
        logic [31:0]                          stall_count;
    } bypass_out_type;

    // A window slot matches a read when it holds a live write to that register.
    function automatic logic addr_match(input logic valid,
                                        input logic [REG_AW-1:0] waddr,
                                        input logic [REG_AW-1:0] raddr);
        return valid && (waddr == raddr);
    endfunction

endpackage

// File: rtl/bypass_network_select.sv
// One read port's priority search over the bypass window, including the
// same-cycle late-result bypass for the entry at LATE_STAGE.
module bypass_select
    import bypass_network_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NSTAGE     = 3,
    parameter int LATE_STAGE = 1
) (
    input  logic                     rden,
    input  logic [4:0]               raddr,
    input  logic [XLEN-1:0]          rdata,
    input  logic [NSTAGE-1:0]        win_valid,
    input  logic [NSTAGE*5-1:0]      win_waddr,
    input  logic [NSTAGE*XLEN-1:0]   win_wdata,
    input  logic [NSTAGE-1:0]        win_ready,
    input  logic                     late_valid,
    input  logic [XLEN-1:0]          late_wdata,
    output logic [XLEN-1:0]          data,
    output logic                     hazard
);

    logic            hit;
    logic            sel_ready;
    logic            sel_late;
    logic [XLEN-1:0] sel_wdata;

    // Scan oldest to youngest so the youngest match is the one left standing,
    // whether or not it is ready.
    always_comb begin
        hit       = 1'b0;
        sel_ready = 1'b0;
        sel_late  = 1'b0;
        sel_wdata = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (addr_match(win_valid[i], win_waddr[i*5 +: 5], raddr)) begin
                hit       = 1'b1;
                sel_ready = win_ready[i];
                sel_wdata = win_wdata[i*XLEN +: XLEN];
                sel_late  = (i == LATE_STAGE);
            end
        end
    end

    always_comb begin
        data   = '0;
        hazard = 1'b0;
        if (rden && (raddr != 5'd0)) begin
            if (!hit) begin
                data = rdata;
            end else if (sel_ready) begin
                data = sel_wdata;
            end else if (sel_late && late_valid) begin
                data = late_wdata;
            end else begin
                hazard = 1'b1;
                data   = rdata;
            end
        end
    end

endmodule

// File: rtl/bypass_network.sv
// Operand-bypass network: shift window of in-flight register writes, late
// result capture, per-port forwarding and a saturating hazard-cycle counter.
module bypass_network
    import bypass_network_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREAD      = 2,
    parameter int NSTAGE     = 3,
    parameter int LATE_STAGE = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     hold,
    input  logic                     issue_wren,
    input  logic [4:0]               issue_waddr,
    input  logic [XLEN-1:0]          issue_wdata,
    input  logic                     issue_ready,
    input  logic                     late_valid,
    input  logic [XLEN-1:0]          late_wdata,
    input  logic [NREAD-1:0]         rden,
    input  logic [NREAD*5-1:0]       raddr,
    input  logic [NREAD*XLEN-1:0]    rdata,
    output logic [NREAD*XLEN-1:0]    data,
    output logic [NREAD-1:0]         hazard,
    output logic [31:0]              stall_count
);

    logic [NSTAGE-1:0]      win_valid;
    logic [NSTAGE-1:0]      win_ready;
    logic [NSTAGE*5-1:0]    win_waddr;
    logic [NSTAGE*XLEN-1:0] win_wdata;
    logic                   late_hit;

    assign late_hit = late_valid && win_valid[LATE_STAGE] && !win_ready[LATE_STAGE];

    always_ff @(posedge clock) begin
        if (reset) begin
            win_valid   <= '0;
            win_ready   <= '0;
            win_waddr   <= '0;
            win_wdata   <= '0;
            stall_count <= '0;
        end else begin
            if (!hold) begin
                win_valid[0]         <= issue_wren && (issue_waddr != 5'd0);
                win_waddr[0 +: 5]    <= issue_waddr;
                win_wdata[0 +: XLEN] <= issue_wdata;
                win_ready[0]         <= issue_ready;
                // A late result completing the LATE_STAGE entry rides along
                // with the shift; at the last stage it simply falls off.
                for (int i = 1; i < NSTAGE; i++) begin
                    win_valid[i]       <= win_valid[i-1];
                    win_waddr[i*5 +: 5] <= win_waddr[(i-1)*5 +: 5];
                    if (late_hit && (i - 1 == LATE_STAGE)) begin
                        win_wdata[i*XLEN +: XLEN] <= late_wdata;
                        win_ready[i]              <= 1'b1;
                    end else begin
                        win_wdata[i*XLEN +: XLEN] <= win_wdata[(i-1)*XLEN +: XLEN];
                        win_ready[i]              <= win_ready[i-1];
                    end
                end
            end else if (late_hit) begin
                win_wdata[LATE_STAGE*XLEN +: XLEN] <= late_wdata;
                win_ready[LATE_STAGE]              <= 1'b1;
            end

            if ((|hazard) && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        bypass_select #(
            .XLEN       (XLEN),
            .NSTAGE     (NSTAGE),
            .LATE_STAGE (LATE_STAGE)
        ) u_select (
            .rden       (rden[p]),
            .raddr      (raddr[p*5 +: 5]),
            .rdata      (rdata[p*XLEN +: XLEN]),
            .win_valid  (win_valid),
            .win_waddr  (win_waddr),
            .win_wdata  (win_wdata),
            .win_ready  (win_ready),
            .late_valid (late_valid),
            .late_wdata (late_wdata),
            .data       (data[p*XLEN +: XLEN]),
            .hazard     (hazard[p])
        );
    end

endmodule

// File: tb/tb_bypass_network.sv
// Directed bench for bypass_network (XLEN=32, NREAD=2, NSTAGE=3, LATE_STAGE=1).
module tb_bypass_network;

    logic        clock = 1'b0;
    logic        reset;
    logic        hold;
    logic        issue_wren;
    logic [4:0]  issue_waddr;
    logic [31:0] issue_wdata;
    logic        issue_ready;
    logic        late_valid;
    logic [31:0] late_wdata;
    logic [1:0]  rden;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [63:0] data;
    logic [1:0]  hazard;
    logic [31:0] stall_count;

    int checks = 0;
    int fails  = 0;

    bypass_network #(.XLEN(32), .NREAD(2), .NSTAGE(3), .LATE_STAGE(1)) dut (
        .clock(clock), .reset(reset), .hold(hold),
        .issue_wren(issue_wren), .issue_waddr(issue_waddr),
        .issue_wdata(issue_wdata), .issue_ready(issue_ready),
        .late_valid(late_valid), .late_wdata(late_wdata),
        .rden(rden), .raddr(raddr), .rdata(rdata),
        .data(data), .hazard(hazard), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [4:0] a, input logic [31:0] d, input logic rdy);
        issue_wren = 1'b1; issue_waddr = a; issue_wdata = d; issue_ready = rdy;
        step();
        issue_wren = 1'b0; issue_waddr = 5'd0; issue_wdata = 32'd0; issue_ready = 1'b0;
    endtask

    task automatic set_port(input int p, input logic en, input logic [4:0] a, input logic [31:0] rd);
        rden[p] = en;
        raddr[p*5 +: 5] = a;
        rdata[p*32 +: 32] = rd;
    endtask

    task automatic drain();
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_port(0, 1'b1, 5'd1, 32'hA000_0001);
        set_port(1, 1'b1, 5'd2, 32'hB000_0002);
        #1;
        checks++; if (data !== 64'hB000_0002_A000_0001) begin fails++; $display("FAIL reset_data got %h want %h", data, 64'hB000_0002_A000_0001); end
        checks++; if (hazard !== 2'b00) begin fails++; $display("FAIL reset_hazard got %b want 00", hazard); end
        checks++; if (stall_count !== 32'd0) begin fails++; $display("FAIL reset_stall got %0d want 0", stall_count); end
    endtask

    task automatic test_forward();
        set_port(0, 1'b1, 5'd5, 32'hDEAD_0005);
        set_port(1, 1'b0, 5'd0, 32'h0);
        issue(5'd5, 32'h11, 1'b1);
        for (int c = 0; c < 3; c++) begin
            checks++; if (data[31:0] !== 32'h11 || hazard[0] !== 1'b0) begin fails++; $display("FAIL fwd_cycle%0d got %h/%b want 00000011/0", c, data[31:0], hazard[0]); end
            step();
        end
        checks++; if (data[31:0] !== 32'hDEAD_0005) begin fails++; $display("FAIL fwd_expired got %h want dead0005", data[31:0]); end
    endtask

    task automatic test_youngest();
        set_port(0, 1'b1, 5'd7, 32'hCAFE_0007);
        issue(5'd7, 32'hAA, 1'b1);
        issue(5'd7, 32'hBB, 1'b1);
        checks++; if (data[31:0] !== 32'hBB) begin fails++; $display("FAIL youngest got %h want 000000bb", data[31:0]); end
        set_port(0, 1'b1, 5'd0, 32'h1234_5678);
        issue(5'd0, 32'hFF, 1'b1);
        checks++; if (data[31:0] !== 32'h0 || hazard[0] !== 1'b0) begin fails++; $display("FAIL x0_read got %h/%b want 0/0", data[31:0], hazard[0]); end
        drain();
    endtask

    task automatic test_late();
        set_port(0, 1'b1, 5'd3, 32'hFACE_0003);
        issue(5'd3, 32'hBAD, 1'b0);
        checks++; if (hazard[0] !== 1'b1) begin fails++; $display("FAIL load_hazard got %b want 1", hazard[0]); end
        step();
        checks++; if (stall_count !== 32'd1) begin fails++; $display("FAIL load_stall got %0d want 1", stall_count); end
        checks++; if (hazard[0] !== 1'b1) begin fails++; $display("FAIL load_hazard_s1 got %b want 1", hazard[0]); end
        late_valid = 1'b1; late_wdata = 32'h1234;
        #1;
        checks++; if (data[31:0] !== 32'h1234 || hazard[0] !== 1'b0) begin fails++; $display("FAIL late_bypass got %h/%b want 00001234/0", data[31:0], hazard[0]); end
        step();
        late_valid = 1'b0; late_wdata = 32'h0;
        #1;
        checks++; if (data[31:0] !== 32'h1234 || hazard[0] !== 1'b0) begin fails++; $display("FAIL late_stored got %h/%b want 00001234/0", data[31:0], hazard[0]); end
        checks++; if (stall_count !== 32'd1) begin fails++; $display("FAIL late_stall got %0d want 1", stall_count); end
        drain();
    endtask

    task automatic test_hold();
        set_port(0, 1'b1, 5'd9, 32'h9999_9999);
        issue(5'd9, 32'h55, 1'b1);
        hold = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (data[31:0] !== 32'h55) begin fails++; $display("FAIL hold_cycle%0d got %h want 00000055", c, data[31:0]); end
        end
        hold = 1'b0;
        issue(5'd10, 32'h0, 1'b0);
        step();
        hold = 1'b1;
        set_port(1, 1'b1, 5'd10, 32'hAAAA_000A);
        #1;
        checks++; if (hazard[1] !== 1'b1) begin fails++; $display("FAIL hold_load_hazard got %b want 1", hazard[1]); end
        late_valid = 1'b1; late_wdata = 32'h77;
        step();
        late_valid = 1'b0; late_wdata = 32'h0;
        step();
        checks++; if (data[63:32] !== 32'h77 || hazard[1] !== 1'b0) begin fails++; $display("FAIL hold_late_inplace got %h/%b want 00000077/0", data[63:32], hazard[1]); end
        checks++; if (data[31:0] !== 32'h55) begin fails++; $display("FAIL hold_x9_entry2 got %h want 00000055", data[31:0]); end
        hold = 1'b0;
        step();
        checks++; if (data[63:32] !== 32'h77) begin fails++; $display("FAIL hold_release_x10 got %h want 00000077", data[63:32]); end
        checks++; if (data[31:0] !== 32'h9999_9999) begin fails++; $display("FAIL hold_release_x9 got %h want 99999999", data[31:0]); end
        drain();
    endtask

    task automatic test_ports();
        issue(5'd4, 32'h44, 1'b1);
        issue(5'd6, 32'h66, 1'b1);
        set_port(0, 1'b1, 5'd4, 32'h0404_0404);
        set_port(1, 1'b1, 5'd6, 32'h0606_0606);
        #1;
        checks++; if (data !== 64'h0000_0066_0000_0044) begin fails++; $display("FAIL ports_indep got %h want 0000006600000044", data); end
        set_port(1, 1'b0, 5'd6, 32'h0606_0606);
        #1;
        checks++; if (data[63:32] !== 32'h0 || hazard[1] !== 1'b0) begin fails++; $display("FAIL port1_disabled got %h/%b want 0/0", data[63:32], hazard[1]); end
        checks++; if (data[31:0] !== 32'h44) begin fails++; $display("FAIL port0_kept got %h want 00000044", data[31:0]); end
        issue(5'd6, 32'h0, 1'b0);
        set_port(0, 1'b1, 5'd6, 32'h0606_0606);
        set_port(1, 1'b1, 5'd4, 32'h0404_0404);
        #1;
        checks++; if (hazard !== 2'b01) begin fails++; $display("FAIL ports_young_notready got %b want 01", hazard); end
        checks++; if (data[63:32] !== 32'h44) begin fails++; $display("FAIL ports_old_x4 got %h want 00000044", data[63:32]); end
        set_port(0, 1'b0, 5'd0, 32'h0);
        set_port(1, 1'b0, 5'd0, 32'h0);
        drain();
    endtask

    task automatic test_reset_mid();
        set_port(0, 1'b1, 5'd3, 32'h3333_3333);
        issue(5'd3, 32'h0, 1'b0);
        step();
        checks++; if (stall_count !== 32'd2) begin fails++; $display("FAIL mid_stall got %0d want 2", stall_count); end
        hold = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        hold = 1'b0;
        #1;
        checks++; if (hazard !== 2'b00 || data[31:0] !== 32'h3333_3333) begin fails++; $display("FAIL mid_reset_window got %h/%b want 33333333/00", data[31:0], hazard); end
        checks++; if (stall_count !== 32'd0) begin fails++; $display("FAIL mid_reset_stall got %0d want 0", stall_count); end
    endtask

    initial begin
        reset = 1'b0; hold = 1'b0;
        issue_wren = 1'b0; issue_waddr = 5'd0; issue_wdata = 32'd0; issue_ready = 1'b0;
        late_valid = 1'b0; late_wdata = 32'd0;
        rden = 2'b00; raddr = 10'd0; rdata = 64'd0;
        test_reset();
        test_forward();
        test_youngest();
        test_late();
        test_hold();
        test_ports();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bypass_network.md
# bypass_network

Parametrised operand-bypass network for the integer pipeline. It tracks the last NSTAGE in-flight register writes in a shift window. It forwards the youngest matching result to each of NREAD read ports and accepts late results (load/multi-cycle data) into a fixed window stage. When the youngest matching producer has no data yet, it raises a per-port hazard. It sits between decode/register-file read and execute, and supersedes the single-stage execute-only forwarding path.

## Interface
- XLEN, 32, data width
- NREAD, 2, number of read ports
- NSTAGE, 3, window depth (entries 0..NSTAGE-1, 0 = youngest)
- LATE_STAGE, 1, window index where late results land; 0 ≤ LATE_STAGE < NSTAGE
- NREAD and NSTAGE ≥ 1
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- hold  in  1  freezes the window (global pipeline stall)
- issue_wren  in  1  instruction leaving execute writes a register
- issue_waddr  in  5  its destination
- issue_wdata  in  XLEN  its result, valid only if issue_ready
- issue_ready  in  1  result available now (0 for loads/multi-cycle ops)
- late_valid  in  1  late result present this cycle
- late_wdata  in  XLEN  late result, for the entry at LATE_STAGE
- rden  in  NREAD  per-port read enable
- raddr  in  NREAD×5  per-port source register
- rdata  in  NREAD×XLEN  register-file read data
- data  out  NREAD×XLEN  forwarded operand
- hazard  out  NREAD  operand not yet available
- stall_count  out  32  cycles with any hazard asserted

## Operation
- Entry fields: valid, waddr, wdata, ready.
- Shift rule, when hold=0 at the edge:
  - entry[i] ← entry[i-1] for i ≥ 1
  - entry[0] ← {issue_wren & (issue_waddr≠0), issue_waddr, issue_wdata, issue_ready}
  - entry[NSTAGE-1] is dropped; its value has been written to the register file.
- When hold=1, all entries keep their position.
- Late completion:
  - Condition: late_valid=1, entry[LATE_STAGE] is valid, and entry[LATE_STAGE].ready=0.
  - The entry takes wdata=late_wdata and ready=1. With hold=0 it is stored in its shifted position (LATE_STAGE+1); if LATE_STAGE = NSTAGE-1 it is dropped.
  - late_valid in any other condition is ignored.
- Per-port select, combinational:
  - If rden=0 or raddr=0: data=0, hazard=0.
  - Otherwise find the lowest index i with entry[i].valid and waddr==raddr.
  - No match: data=rdata.
  - Match with ready=1: data=entry[i].wdata.
  - Match with ready=0, i==LATE_STAGE and late_valid=1: data=late_wdata, hazard=0 (same-cycle bypass).
  - Match with ready=0 otherwise: hazard=1, data=rdata (don't-care, but deterministic).
  - An older ready match never overrides a younger not-ready one.
- stall_count increments by 1 on each edge where |hazard=1, saturates at 0xFFFF_FFFF, and is not affected by hold.
- Decode converts hazard into not issuing, so issue_wren=0 inserts a bubble. The network itself never stalls.

## Timing
- data and hazard: zero latency, combinational from the current window and the inputs.
- An issued result is forwardable from the cycle after issue and stays forwardable for NSTAGE cycles (with hold=0), then comes from the register file.
- Reset (even mid-operation or with hold=1): every entry valid=0 and stall_count=0 at the next edge. Outputs then read data=rdata masked by rden/x0, hazard=0.
- Simultaneous hold=1 and late_valid=1: the late entry becomes ready in place and no shift happens.

## Structure
- In package wires: bypass_entry_type struct {valid, waddr[4:0], wdata[31:0], ready}; bypass_in_type and bypass_out_type bundling the ports above, following the existing forwarding_in_type/forwarding_out_type pattern.
- Sub-module bypass_select: one read port's priority search over the window plus the late-bypass term, instantiated NREAD times with a generate loop.
- Top level holds the window registers, the late-write logic and stall_count.

## Test plan
- Issue x5=0x11 (ready) → next cycle read x5 gives 0x11, hazard=0; after 3 unheld cycles, gives rdata.
- Issue x7=0xAA then x7=0xBB on consecutive cycles → read x7 gives 0xBB (youngest wins); x0 write of 0xFF → read x0 gives 0.
- Load x3 (issue_ready=0) → next cycle read x3 gives hazard=1, stall_count increments. With LATE_STAGE=1 and late_valid with 0x1234 one cycle later → hazard=0, data=0x1234 same cycle, and 0x1234 is still forwarded the following cycle.
- hold=1 for 4 cycles after issuing x9=0x55 → x9 still gives 0x55 throughout; a late_valid during hold marks the entry ready in place.
- Both ports reading x4 and x6 with different window matches → independent data per port; rden=0 on port 1 → data[1]=0, hazard[1]=0.
- reset asserted with a pending not-ready load in the window → window empty next cycle, hazard=0, stall_count=0.
